pipe_acc16_loader: RTL and testbench

Program loader for the pipeAcc16 accumulator core: accepts a byte stream over a valid/ready handshake, assembles big-endian 16-bit words, and writes them into the core's unified 1024-word memory image (instruction region then data region). It also holds the core idle until a run command arrives. It sits between the host link and the core's memory write port and acts as the memory writer for the core, which only reads instructions and operands.

---
 rtl/pipe_acc16_loader.sv | 142 ++++++++++++++
 tb/tb_pipe_acc16_loader.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/pipe_acc16_loader.sv
// Byte-stream program loader for the pipeAcc16 core: framed big-endian word
// writes into the unified memory image, then releases the core on a run command.
module pipe_acc16_loader #(
   parameter int L_INS = 401,
   parameter int L_TOT = 1024,
   parameter int AW    = 10
) (
   input  logic          clk1,
   input  logic          rst,
   input  logic          in_valid,
   input  logic [7:0]    in_data,
   output logic          in_ready,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [15:0]   mem_wdata,
   output logic          core_run,
   output logic          load_done,
   output logic          err,
   output logic [AW-1:0] words_loaded
);

   if (L_INS > L_TOT) begin : g_bad_param
      $error("instruction region larger than memory");
   end

   typedef enum logic [3:0] {
      IDLE, ADDR_H, ADDR_L, CNT_H, CNT_L, DAT_H, DAT_L, CHK, RUN, ERR
   } state_t;

   localparam logic [7:0] CMD_LOAD = 8'hA5;
   localparam logic [7:0] CMD_RUN  = 8'h5A;
   localparam logic [AW:0] TOT     = (AW+1)'(L_TOT);

   state_t        state, state_nx;
   logic [AW-1:0] start, cnt, idx;
   logic [7:0]    chk, dat_h;
   logic          acc, over, last;
   logic [AW:0]   end_addr;

   assign acc      = in_valid && in_ready;
   // CNT_L is still on in_data when the bound is checked
   assign end_addr = {1'b0, start} + {1'b0, cnt[AW-1:8], in_data};
   assign over     = end_addr > TOT;
   assign last     = ({1'b0, idx} + 1'b1) == {1'b0, cnt};

   always_ff @(posedge clk1 or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      if (acc) begin
         case (state)
            IDLE:    if (in_data == CMD_LOAD)     state_nx = ADDR_H;
                     else if (in_data == CMD_RUN) state_nx = RUN;
            ADDR_H:  state_nx = ADDR_L;
            ADDR_L:  state_nx = CNT_H;
            CNT_H:   state_nx = CNT_L;
            CNT_L:   if (over) state_nx = ERR;
                     else if ({cnt[AW-1:8], in_data} == '0) state_nx = CHK;
                     else state_nx = DAT_H;
            DAT_H:   state_nx = DAT_L;
            DAT_L:   state_nx = last ? CHK : DAT_H;
            CHK:     state_nx = (in_data == chk) ? IDLE : ERR;
            default: state_nx = state;
         endcase
      end
   end

   always_comb begin
      in_ready = 1'b1;
      if (state == RUN || state == ERR) in_ready = 1'b0;
   end

   always_ff @(posedge clk1 or negedge rst) begin
      if (!rst) begin
         start        <= '0;
         cnt          <= '0;
         idx          <= '0;
         chk          <= '0;
         dat_h        <= '0;
         mem_we       <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         core_run     <= 1'b0;
         load_done    <= 1'b0;
         err          <= 1'b0;
         words_loaded <= '0;
      end else begin
         mem_we    <= 1'b0;
         load_done <= 1'b0;
         if (acc) begin
            case (state)
               IDLE: begin
                  if (in_data == CMD_LOAD) begin
                     words_loaded <= '0;
                     chk          <= '0;
                     idx          <= '0;
                  end
                  if (in_data == CMD_RUN) core_run <= 1'b1;
               end
               ADDR_H: begin
                  start[AW-1:8] <= in_data[AW-9:0];
                  chk           <= chk ^ in_data;
               end
               ADDR_L: begin
                  start[7:0] <= in_data;
                  chk        <= chk ^ in_data;
               end
               CNT_H: begin
                  cnt[AW-1:8] <= in_data[AW-9:0];
                  chk         <= chk ^ in_data;
               end
               CNT_L: begin
                  cnt[7:0] <= in_data;
                  chk      <= chk ^ in_data;
                  if (over) err <= 1'b1;
               end
               DAT_H: begin
                  dat_h <= in_data;
                  chk   <= chk ^ in_data;
               end
               DAT_L: begin
                  chk          <= chk ^ in_data;
                  mem_we       <= 1'b1;
                  mem_addr     <= start + idx;
                  mem_wdata    <= {dat_h, in_data};
                  words_loaded <= words_loaded + 1'b1;
                  idx          <= idx + 1'b1;
               end
               CHK: begin
                  if (in_data == chk) load_done <= 1'b1;
                  else                err       <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pipe_acc16_loader.sv
// Directed table-driven bench for pipe_acc16_loader: one byte per vector,
// outputs compared one cycle after each byte, plus async-reset checks.
module tb_pipe_acc16_loader;

   typedef struct packed {
      logic        we;
      logic [9:0]  addr;
      logic [15:0] wdata;
      logic        done;
      logic        err;
      logic        run;
      logic        ready;
      logic [9:0]  wl;
   } obs_t;

   typedef struct {
      logic       v;
      logic [7:0] d;
      obs_t       exp;
      logic       ra;
   } vec_t;

   logic        clk1 = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready, mem_we, core_run, load_done, err;
   logic [9:0]  mem_addr, words_loaded;
   logic [15:0] mem_wdata;

   int n_chk = 0;
   int n_fail = 0;
   int n_wr = 0;
   logic [15:0] mem [0:1023];
   vec_t tbl[$];

   pipe_acc16_loader dut (
      .clk1(clk1), .rst(rst), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .core_run(core_run), .load_done(load_done),
      .err(err), .words_loaded(words_loaded)
   );

   always #5 clk1 = ~clk1;

   always @(posedge clk1) begin
      if (mem_we) begin
         mem[mem_addr] <= mem_wdata;
         n_wr = n_wr + 1;
      end
   end

   function automatic obs_t e(input logic we, input logic [9:0] addr,
                              input logic [15:0] wdata, input logic done,
                              input logic er, input logic run, input logic rdy,
                              input logic [9:0] wl);
      return '{we, addr, wdata, done, er, run, rdy, wl};
   endfunction

   task automatic add(input logic v, input logic [7:0] d, input obs_t x, input logic ra = 1'b0);
      tbl.push_back('{v, d, x, ra});
   endtask

   task automatic check(input string nm, input obs_t x);
      obs_t a;
      a = '{mem_we, mem_addr, mem_wdata, load_done, err, core_run, in_ready, words_loaded};
      n_chk++;
      if (a !== x) begin
         n_fail++;
         $display("FAIL %s: got we=%b addr=%h wd=%h done=%b err=%b run=%b rdy=%b wl=%0d, expected we=%b addr=%h wd=%h done=%b err=%b run=%b rdy=%b wl=%0d",
                  nm, a.we, a.addr, a.wdata, a.done, a.err, a.run, a.ready, a.wl,
                  x.we, x.addr, x.wdata, x.done, x.err, x.run, x.ready, x.wl);
      end
   endtask

   task automatic cmp16(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic async_reset();
      rst = 1'b0;
      #1;
      check("async_reset", e(0, 0, 0, 0, 0, 0, 1, 0));
      @(negedge clk1);
      rst = 1'b1;
   endtask

   obs_t z, h1, h2, h3;

   initial begin
      rst = 1'b0;
      in_valid = 1'b0;
      in_data = 8'h00;
      z = e(0, 0, 0, 0, 0, 0, 1, 0);
      #12;
      check("reset_state", z);
      @(negedge clk1);
      rst = 1'b1;

      // good frame: addr 0, two words, CHK 0x42
      add(1, 8'hA5, z); add(1, 8'h00, z); add(1, 8'h00, z);
      add(1, 8'h00, z); add(1, 8'h02, z); add(1, 8'h12, z);
      add(1, 8'h34, e(1, 10'h000, 16'h1234, 0, 0, 0, 1, 1));
      add(1, 8'hAB, e(0, 10'h000, 16'h1234, 0, 0, 0, 1, 1));
      add(1, 8'hCD, e(1, 10'h001, 16'hABCD, 0, 0, 0, 1, 2));
      add(1, 8'h42, e(0, 10'h001, 16'hABCD, 1, 0, 0, 1, 2));
      // edge fit: addr 0x3FF, one word, CHK 0xAC
      h1 = e(0, 10'h001, 16'hABCD, 0, 0, 0, 1, 0);
      add(1, 8'hA5, h1); add(1, 8'h03, h1); add(1, 8'hFF, h1);
      add(1, 8'h00, h1); add(1, 8'h01, h1); add(1, 8'hBE, h1);
      add(1, 8'hEF, e(1, 10'h3FF, 16'hBEEF, 0, 0, 0, 1, 1));
      add(1, 8'hAC, e(0, 10'h3FF, 16'hBEEF, 1, 0, 0, 1, 1));
      // resync junk, then bad-checksum frame with one stall cycle
      h2 = e(0, 10'h3FF, 16'hBEEF, 0, 0, 0, 1, 1);
      add(1, 8'h00, h2); add(1, 8'hFF, h2);
      h3 = e(0, 10'h3FF, 16'hBEEF, 0, 0, 0, 1, 0);
      add(1, 8'hA5, h3); add(1, 8'h00, h3); add(1, 8'h00, h3);
      add(0, 8'h77, h3);
      add(1, 8'h00, h3); add(1, 8'h02, h3); add(1, 8'h12, h3);
      add(1, 8'h34, e(1, 10'h000, 16'h1234, 0, 0, 0, 1, 1));
      add(1, 8'hAB, e(0, 10'h000, 16'h1234, 0, 0, 0, 1, 1));
      add(1, 8'hCD, e(1, 10'h001, 16'hABCD, 0, 0, 0, 1, 2));
      add(1, 8'h43, e(0, 10'h001, 16'hABCD, 0, 1, 0, 0, 2));
      add(1, 8'h5A, e(0, 10'h001, 16'hABCD, 0, 1, 0, 0, 2), 1);
      // bound violation: 0x3FF + 2 > 1024
      add(1, 8'hA5, z); add(1, 8'h03, z); add(1, 8'hFF, z); add(1, 8'h00, z);
      add(1, 8'h02, e(0, 0, 0, 0, 1, 0, 0, 0));
      add(1, 8'h12, e(0, 0, 0, 0, 1, 0, 0, 0), 1);
      // resync then run; further bytes ignored
      add(1, 8'h00, z); add(1, 8'hFF, z);
      add(1, 8'h5A, e(0, 0, 0, 0, 0, 1, 0, 0));
      add(1, 8'hA5, e(0, 0, 0, 0, 0, 1, 0, 0), 1);
      // reset while a write is pending
      add(1, 8'hA5, z); add(1, 8'h00, z); add(1, 8'h10, z);
      add(1, 8'h00, z); add(1, 8'h01, z); add(1, 8'h77, z);
      add(1, 8'h88, e(1, 10'h010, 16'h7788, 0, 0, 0, 1, 1), 1);
      // recovery frame: addr 5, word 0xCAFE, CHK 0x30
      add(1, 8'hA5, z); add(1, 8'h00, z); add(1, 8'h05, z);
      add(1, 8'h00, z); add(1, 8'h01, z); add(1, 8'hCA, z);
      add(1, 8'hFE, e(1, 10'h005, 16'hCAFE, 0, 0, 0, 1, 1));
      add(1, 8'h30, e(0, 10'h005, 16'hCAFE, 1, 0, 0, 1, 1));

      foreach (tbl[i]) begin
         in_valid = tbl[i].v;
         in_data  = tbl[i].d;
         @(posedge clk1);
         #1;
         in_valid = 1'b0;
         check($sformatf("vec%0d_%h", i, tbl[i].d), tbl[i].exp);
         if (tbl[i].ra) async_reset();
      end

      @(posedge clk1);
      #1;
      cmp16("mem_000", mem[10'h000], 16'h1234);
      cmp16("mem_001", mem[10'h001], 16'hABCD);
      cmp16("mem_3ff", mem[10'h3FF], 16'hBEEF);
      cmp16("mem_005", mem[10'h005], 16'hCAFE);
      cmp16("write_count", 16'(n_wr), 16'd6);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
